// File: rtl/ddr3_arb_pkg.sv
// Shared widths, port id and read-tag types for the two-port DDR3 arbiter.
package ddr3_arb_pkg;
    localparam int unsigned ADDR_W = 29;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BC_W   = 8;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    typedef struct packed {
        port_t           port;
        logic [BC_W-1:0] burstcnt;
    } tag_t;
endpackage

// File: rtl/ddr3_arbiter_if.sv
// Avalon-MM command/response bundle; master drives commands, slave answers.
interface ddr3_arbiter_if;
    import ddr3_arb_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [BC_W-1:0]   burstcnt;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output addr, burstcnt, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  addr, burstcnt, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ddr3_arb_tag_fifo.sv
// In-order read-tag FIFO; a push into a full FIFO is honoured when a pop frees the slot.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  tag_t i_tag,
    input  logic i_pop,
    output tag_t o_head,
    output logic o_full,
    output logic o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    tag_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        o_full  = (r_count == CNT_FULL);
        o_empty = (r_count == '0);
        w_pop   = i_pop & ~o_empty;
        w_push  = i_push & (~o_full | w_pop);
        o_head  = r_mem[r_rptr];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/ddr3_arbiter.sv
// Two-port Avalon-MM arbiter onto one DDR3 master with tagged in-order read return.
// Define DDR3_ARB_RR_EN for round-robin; otherwise port 0 wins contention.
module ddr3_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic           clk,
    input  logic           rst,
    ddr3_arbiter_if.slave  p0,
    ddr3_arbiter_if.slave  p1,
    ddr3_arbiter_if.master ddr3,
    output logic [1:0]     dbg_grant,
    output logic           dbg_orphan
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;
    localparam logic [BC_W-1:0] BC_ONE = 1;

    logic [0:0]      r_state;
    logic [1:0]      r_grant;
    logic [BC_W-1:0] r_beats;
    logic [BC_W-1:0] r_ret_cnt;
    logic            r_orphan;

    logic              w_own, w_sel, w_req0, w_req1, w_pick1;
    logic [ADDR_W-1:0] w_g_addr;
    logic [BC_W-1:0]   w_g_burstcnt, w_g_bc;
    logic              w_g_read, w_g_write, w_g_wait, w_rd_stall;
    logic [DATA_W-1:0] w_g_wdata;
    logic [BE_W-1:0]   w_g_be;
    logic              w_rd_acc, w_wr_acc, w_pop;
    logic              w_fifo_full, w_fifo_empty;
    tag_t              w_head, w_push_tag;

`ifdef DDR3_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (r_state == IDLE && (w_req0 || w_req1)) begin
            r_last <= w_pick1;
        end
    end

    assign w_pick1 = w_req1 & (~w_req0 | ~r_last);
`else
    assign w_pick1 = w_req1 & ~w_req0;
`endif

    always_comb begin
        w_own        = (r_state == OWN);
        w_sel        = r_grant[1];
        w_req0       = p0.read | p0.write;
        w_req1       = p1.read | p1.write;
        w_g_addr     = w_sel ? p1.addr       : p0.addr;
        w_g_burstcnt = w_sel ? p1.burstcnt   : p0.burstcnt;
        w_g_read     = w_sel ? p1.read       : p0.read;
        w_g_write    = w_sel ? p1.write      : p0.write;
        w_g_wdata    = w_sel ? p1.writedata  : p0.writedata;
        w_g_be       = w_sel ? p1.byteenable : p0.byteenable;
        w_g_bc       = (w_g_burstcnt == '0) ? BC_ONE : w_g_burstcnt;

        // A read-return pop in this cycle frees a tag slot for this cycle's read.
        w_pop      = ddr3.readdatavalid & ~w_fifo_empty & ((r_ret_cnt + BC_ONE) == w_head.burstcnt);
        w_rd_stall = w_g_read & w_fifo_full & ~w_pop;
        w_g_wait   = ddr3.waitrequest | w_rd_stall;
        w_rd_acc   = w_own & w_g_read & ~w_g_wait;
        w_wr_acc   = w_own & w_g_write & ~w_g_wait;

        ddr3.addr       = w_g_addr;
        ddr3.burstcnt   = w_g_burstcnt;
        ddr3.read       = w_own & w_g_read & ~w_rd_stall;
        ddr3.write      = w_own & w_g_write;
        ddr3.writedata  = w_g_wdata;
        ddr3.byteenable = w_g_be;

        p0.waitrequest   = ~(w_own & ~w_sel) | w_g_wait;
        p1.waitrequest   = ~(w_own & w_sel) | w_g_wait;
        p0.readdata      = ddr3.readdata;
        p1.readdata      = ddr3.readdata;
        p0.readdatavalid = ddr3.readdatavalid & ~w_fifo_empty & (w_head.port == PORT0);
        p1.readdatavalid = ddr3.readdatavalid & ~w_fifo_empty & (w_head.port == PORT1);

        w_push_tag.port     = port_t'(w_sel);
        w_push_tag.burstcnt = w_g_bc;

        dbg_grant  = r_grant;
        dbg_orphan = r_orphan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_beats <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                        r_state <= OWN;
                    end
                end
                default: begin
                    if (w_rd_acc) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end else if (w_wr_acc) begin
                        // r_beats holds beats still owed after the current one.
                        if (r_beats == '0) begin
                            if (w_g_bc == BC_ONE) begin
                                r_state <= IDLE;
                                r_grant <= 2'b00;
                            end else begin
                                r_beats <= w_g_bc - BC_ONE;
                            end
                        end else begin
                            r_beats <= r_beats - BC_ONE;
                            if (r_beats == BC_ONE) begin
                                r_state <= IDLE;
                                r_grant <= 2'b00;
                            end
                        end
                    end else if (!w_g_read && !w_g_write && r_beats == '0) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_cnt <= '0;
            r_orphan  <= 1'b0;
        end else if (ddr3.readdatavalid) begin
            if (w_fifo_empty) begin
                r_orphan <= 1'b1;
            end else if (w_pop) begin
                r_ret_cnt <= '0;
            end else begin
                r_ret_cnt <= r_ret_cnt + BC_ONE;
            end
        end
    end

    ddr3_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rd_acc),
        .i_tag   (w_push_tag),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );
endmodule

// File: tb/tb_ddr3_arbiter.sv
// Directed self-checking bench for ddr3_arbiter (fixed-priority or DDR3_ARB_RR_EN build).
module tb_ddr3_arbiter;
    import ddr3_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_grant;
    logic       dbg_orphan;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_g [4];

    ddr3_arbiter_if p0_if ();
    ddr3_arbiter_if p1_if ();
    ddr3_arbiter_if ddr3_if ();

    ddr3_arbiter #(
        .MAX_OUTSTANDING (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p0         (p0_if),
        .p1         (p1_if),
        .ddr3       (ddr3_if),
        .dbg_grant  (dbg_grant),
        .dbg_orphan (dbg_orphan)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DDR3_ARB_RR_EN
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst = 1'b1;
        p0_if.addr = '0; p0_if.burstcnt = '0; p0_if.read = 0; p0_if.write = 0;
        p0_if.writedata = '0; p0_if.byteenable = 8'hFF;
        p1_if.addr = '0; p1_if.burstcnt = '0; p1_if.read = 0; p1_if.write = 0;
        p1_if.writedata = '0; p1_if.byteenable = 8'hFF;
        ddr3_if.waitrequest = 0; ddr3_if.readdata = '0; ddr3_if.readdatavalid = 0;
        #2;
        chk("rst_rd", ddr3_if.read, 0);
        chk("rst_wr", ddr3_if.write, 0);
        chk("rst_w0", p0_if.waitrequest, 1);
        chk("rst_w1", p1_if.waitrequest, 1);
        chk("rst_rdv0", p0_if.readdatavalid, 0);
        chk("rst_grant", dbg_grant, 0);
        chk("rst_orphan", dbg_orphan, 0);
        tick(); tick();
        rst = 1'b0;

        // Port 0 read of 4 beats at 0x100.
        tick();
        p0_if.read = 1; p0_if.addr = 29'h100; p0_if.burstcnt = 8'd4;
        settle();
        chk("t1_bubble_rd", ddr3_if.read, 0);
        chk("t1_bubble_w0", p0_if.waitrequest, 1);
        tick();
        chk("t1_rd", ddr3_if.read, 1);
        chk("t1_addr", ddr3_if.addr, 29'h100);
        chk("t1_bc", ddr3_if.burstcnt, 4);
        chk("t1_w0", p0_if.waitrequest, 0);
        chk("t1_grant", dbg_grant, 2'b01);
        tick();
        p0_if.read = 0;
        settle();
        chk("t1_rd_once", ddr3_if.read, 0);
        for (int i = 0; i < 4; i++) begin
            ddr3_if.readdatavalid = 1; ddr3_if.readdata = 64'hA0 + 64'(i);
            settle();
            chk("t1_rdv0", p0_if.readdatavalid, 1);
            chk("t1_rdv1", p1_if.readdatavalid, 0);
            chk("t1_data", p0_if.readdata, 64'hA0 + 64'(i));
            tick();
        end
        ddr3_if.readdatavalid = 0;
        chk("t1_empty", dut.w_fifo_empty, 1);

        // Port 1 3-beat write; port 0 read arrives on the second beat.
        p1_if.write = 1; p1_if.burstcnt = 8'd3; p1_if.addr = 29'h40; p1_if.writedata = 64'hD0;
        tick();
        chk("t2_b0_wr", ddr3_if.write, 1);
        chk("t2_b0_data", ddr3_if.writedata, 64'hD0);
        chk("t2_b0_w1", p1_if.waitrequest, 0);
        chk("t2_b0_grant", dbg_grant, 2'b10);
        tick();
        p1_if.writedata = 64'hD1;
        p0_if.read = 1; p0_if.addr = 29'h200; p0_if.burstcnt = 8'd1;
        settle();
        chk("t2_b1_wr", ddr3_if.write, 1);
        chk("t2_b1_data", ddr3_if.writedata, 64'hD1);
        chk("t2_b1_w0", p0_if.waitrequest, 1);
        chk("t2_b1_grant", dbg_grant, 2'b10);
        tick();
        p1_if.writedata = 64'hD2;
        settle();
        chk("t2_b2_wr", ddr3_if.write, 1);
        chk("t2_b2_data", ddr3_if.writedata, 64'hD2);
        chk("t2_b2_grant", dbg_grant, 2'b10);
        tick();
        p1_if.write = 0;
        settle();
        chk("t2_idle_grant", dbg_grant, 2'b00);
        chk("t2_idle_rd", ddr3_if.read, 0);
        tick();
        chk("t2_p0_grant", dbg_grant, 2'b01);
        chk("t2_p0_rd", ddr3_if.read, 1);
        chk("t2_p0_addr", ddr3_if.addr, 29'h200);
        tick();
        p0_if.read = 0;
        ddr3_if.readdatavalid = 1;
        settle();
        chk("t2_rdv0", p0_if.readdatavalid, 1);
        tick();
        ddr3_if.readdatavalid = 0;

        // Both ports read continuously.
        p0_if.read = 1; p0_if.burstcnt = 8'd1;
        p1_if.read = 1; p1_if.burstcnt = 8'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_grant", dbg_grant, exp_g[k]);
            tick();
        end
        p0_if.read = 0; p1_if.read = 0;
        for (int k = 0; k < 4; k++) begin
            ddr3_if.readdatavalid = 1;
            settle();
            chk("t3_rdv0", p0_if.readdatavalid, exp_g[k][0]);
            chk("t3_rdv1", p1_if.readdatavalid, exp_g[k][1]);
            tick();
        end
        ddr3_if.readdatavalid = 0;
        chk("t3_empty", dut.w_fifo_empty, 1);

        // Fill the tag FIFO with 16 single-beat reads; the 17th stalls.
        p0_if.read = 1; p0_if.burstcnt = 8'd1;
        for (int k = 0; k < 16; k++) begin
            tick();
            tick();
        end
        tick();
        chk("t4_full", dut.w_fifo_full, 1);
        chk("t4_stall", p0_if.waitrequest, 1);
        tick();
        chk("t4_stall2", p0_if.waitrequest, 1);
        chk("t4_stall2_grant", dbg_grant, 2'b01);
        ddr3_if.readdatavalid = 1;
        settle();
        chk("t4_release", p0_if.waitrequest, 0);
        chk("t4_release_rd", ddr3_if.read, 1);
        chk("t4_release_rdv", p0_if.readdatavalid, 1);
        tick();
        p0_if.read = 0;
        ddr3_if.readdatavalid = 0;
        settle();
        chk("t4_still_full", dut.w_fifo_full, 1);
        for (int k = 0; k < 16; k++) begin
            ddr3_if.readdatavalid = 1;
            settle();
            chk("t4_drain_rdv0", p0_if.readdatavalid, 1);
            tick();
        end
        ddr3_if.readdatavalid = 0;
        chk("t4_empty", dut.w_fifo_empty, 1);

        // Orphan beat.
        ddr3_if.readdatavalid = 1;
        settle();
        chk("t5_rdv0", p0_if.readdatavalid, 0);
        chk("t5_rdv1", p1_if.readdatavalid, 0);
        tick();
        ddr3_if.readdatavalid = 0;
        chk("t5_orphan", dbg_orphan, 1);
        tick(); tick();
        chk("t5_orphan_sticky", dbg_orphan, 1);

        // Reset during the second beat of a 4-beat write.
        p0_if.write = 1; p0_if.burstcnt = 8'd4; p0_if.writedata = 64'hE0;
        tick();
        chk("t6_b0_wr", ddr3_if.write, 1);
        tick();
        p0_if.writedata = 64'hE1;
        settle();
        chk("t6_b1_wr", ddr3_if.write, 1);
        rst = 1'b1;
        settle();
        chk("t6_rst_wr", ddr3_if.write, 0);
        chk("t6_rst_rd", ddr3_if.read, 0);
        chk("t6_rst_w0", p0_if.waitrequest, 1);
        chk("t6_rst_w1", p1_if.waitrequest, 1);
        chk("t6_rst_grant", dbg_grant, 0);
        chk("t6_rst_orphan", dbg_orphan, 0);
        settle();
        rst = 1'b0;
        tick();
        chk("t6_regrant", dbg_grant, 2'b01);
        chk("t6_regrant_wr", ddr3_if.write, 1);
        chk("t6_regrant_bc", ddr3_if.burstcnt, 4);
        p0_if.write = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
